// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite four-word register slave: CTRL, DATA, SUM (RO), WCNT (RO).
// Define AXI_REG_SLAVE_WCNT_EN to implement the write counter at 0xC.
module axi_lite_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DATA_WIDTH-1:0] reg_ctrl;
  logic [DATA_WIDTH-1:0] reg_data;
  logic [DATA_WIDTH-1:0] reg_sum;
`ifdef AXI_REG_SLAVE_WCNT_EN
  logic [DATA_WIDTH-1:0] reg_wcnt;
`endif

  logic                  aw_got;
  logic                  w_got;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NB-1:0]         w_strb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [NB-1:0]         cur_strb;
  logic [2:0]            wr_dec;
  logic [2:0]            rd_dec;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_strb;

  // Returns {valid, word index}; BASE is 16-byte aligned so offset bits suffice
  function automatic logic [2:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE;
    return {(a >= BASE) && (off[ADDR_WIDTH-1:4] == '0) && (off[1:0] == 2'b00),
            off[3:2]};
  endfunction

  assign unused_strb = s_axi_wstrb[NB];
  assign reg_sum  = reg_ctrl + reg_data;

  assign aw_hs    = s_axi_awvalid & s_axi_awready;
  assign w_hs     = s_axi_wvalid & s_axi_wready;
  assign ar_hs    = s_axi_arvalid & s_axi_arready & (r_state == R_IDLE);
  assign commit   = (w_state == W_IDLE) & (aw_got | aw_hs) & (w_got | w_hs);
  assign cur_addr = aw_got ? aw_addr_q : s_axi_awaddr;
  assign cur_data = w_got ? w_data_q : s_axi_wdata;
  assign cur_strb = w_got ? w_strb_q : s_axi_wstrb[NB-1:0];
  assign wr_dec   = decode(cur_addr);
  assign wr_ok    = wr_dec[2] & ~wr_dec[1];
  assign rd_dec   = decode(s_axi_araddr);

  always_comb begin
    wr_word = wr_dec[0] ? reg_data : reg_ctrl;
    for (int i = 0; i < NB; i++) begin
      if (cur_strb[i]) wr_word[8*i +: 8] = cur_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_val = '0;
    if (rd_dec[2]) begin
      unique case (rd_dec[1:0])
        2'd0: rd_val = reg_ctrl;
        2'd1: rd_val = reg_data;
        2'd2: rd_val = reg_sum;
`ifdef AXI_REG_SLAVE_WCNT_EN
        2'd3: rd_val = reg_wcnt;
`else
        2'd3: rd_val = '0;
`endif
      endcase
    end
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (commit) w_next = W_RESP;
      W_RESP: if (s_axi_bready) w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_next = R_DATA;
      R_DATA: if (s_axi_rready) r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      reg_ctrl      <= '0;
      reg_data      <= '0;
`ifdef AXI_REG_SLAVE_WCNT_EN
      reg_wcnt      <= '0;
`endif
    end else if (w_state == W_IDLE) begin
      if (commit) begin
        aw_got        <= 1'b0;
        w_got         <= 1'b0;
        s_axi_awready <= 1'b0;
        s_axi_wready  <= 1'b0;
        s_axi_bvalid  <= 1'b1;
        s_axi_bresp   <= wr_ok ? OKAY : SLVERR;
        if (wr_ok) begin
          if (wr_dec[0]) reg_data <= wr_word;
          else           reg_ctrl <= wr_word;
`ifdef AXI_REG_SLAVE_WCNT_EN
          reg_wcnt <= reg_wcnt + 1'b1;
`endif
        end
      end else begin
        if (aw_hs) begin
          aw_got    <= 1'b1;
          aw_addr_q <= s_axi_awaddr;
        end
        if (w_hs) begin
          w_got    <= 1'b1;
          w_data_q <= s_axi_wdata;
          w_strb_q <= s_axi_wstrb[NB-1:0];
        end
        s_axi_awready <= ~(aw_got | aw_hs);
        s_axi_wready  <= ~(w_got | w_hs);
      end
    end else if (s_axi_bready) begin
      s_axi_bvalid  <= 1'b0;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
    end
  end

  // Read data sampled before any same-edge write commit lands
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        s_axi_arready <= 1'b0;
        s_axi_rvalid  <= 1'b1;
        s_axi_rdata   <= rd_val;
        s_axi_rresp   <= rd_dec[2] ? OKAY : SLVERR;
      end else begin
        s_axi_arready <= 1'b1;
      end
    end else if (s_axi_rready) begin
      s_axi_rvalid  <= 1'b0;
      s_axi_arready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed self-checking bench for axi_lite_reg_slave.
// Expectations for 0xC follow AXI_REG_SLAVE_WCNT_EN.
module tb_axi_lite_reg_slave;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [4:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [2:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [2:0]  rresp;
  logic        rvalid;
  logic        rready;

  int total  = 0;
  int passed = 0;

`ifdef AXI_REG_SLAVE_WCNT_EN
  localparam bit WC_ON = 1'b1;
`else
  localparam bit WC_ON = 1'b0;
`endif

  axi_lite_reg_slave dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (aresetn),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic idle_inputs();
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arvalid = 0; rready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    aresetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [4:0] s, output logic [2:0] resp,
                    output logic lat);
    int n;
    logic ha, hw;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      @(negedge clk);
      ha = awvalid & awready;
      hw = wvalid & wready;
      @(posedge clk); #1;
      if (ha) awvalid = 0;
      if (hw) wvalid = 0;
      n++;
    end
    awvalid = 0; wvalid = 0;
    lat = bvalid;
    n = 0;
    while (!bvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bvalid) begin
      total++;
      $display("FAIL wr_timeout addr=%h bvalid=%b required=1", a, bvalid);
    end
    resp = bresp;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d,
                    output logic [2:0] resp, output logic lat);
    int n;
    logic h;
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    while (arvalid && n < 20) begin
      @(negedge clk);
      h = arvalid & arready;
      @(posedge clk); #1;
      if (h) arvalid = 0;
      n++;
    end
    arvalid = 0;
    lat = rvalid;
    n = 0;
    while (!rvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rvalid) begin
      total++;
      $display("FAIL rd_timeout addr=%h rvalid=%b required=1", a, rvalid);
    end
    d = rdata;
    resp = rresp;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
      $display("FAIL reset_hs got=%b required=00000",
               {awready, wready, arready, bvalid, rvalid});
    else passed++;
    total++;
    if ({bresp, rresp, rdata} !== 38'h0)
      $display("FAIL reset_data bresp=%h rresp=%h rdata=%h required=0",
               bresp, rresp, rdata);
    else passed++;
    @(negedge clk);
    aresetn = 1;
    @(posedge clk); #1;
    total++;
    if ({awready, wready, arready} !== 3'b111)
      $display("FAIL reset_release got=%b required=111",
               {awready, wready, arready});
    else passed++;
  endtask

  task automatic test_basic();
    logic [2:0] r; logic l; logic [31:0] d;
    wr(8'h00, 32'h0000_0005, 5'hF, r, l);
    total++;
    if (r !== 3'd0) $display("FAIL basic_bresp got=%0d required=0", r);
    else passed++;
    total++;
    if (l !== 1'b1) $display("FAIL basic_blat got=%b required=1", l);
    else passed++;
    rd(8'h00, d, r, l);
    total++;
    if (d !== 32'h5 || r !== 3'd0)
      $display("FAIL basic_read got=%h/%0d required=5/0", d, r);
    else passed++;
    total++;
    if (l !== 1'b1) $display("FAIL basic_rlat got=%b required=1", l);
    else passed++;
  endtask

  task automatic test_sum();
    logic [2:0] r; logic l; logic [31:0] d;
    do_reset();
    wr(8'h00, 32'hFFFF_FFFF, 5'hF, r, l);
    wr(8'h04, 32'h0000_0002, 5'hF, r, l);
    rd(8'h08, d, r, l);
    total++;
    if (d !== 32'h1 || r !== 3'd0)
      $display("FAIL sum_wrap got=%h/%0d required=1/0", d, r);
    else passed++;
    rd(8'h0C, d, r, l);
    total++;
    if (d !== (WC_ON ? 32'd2 : 32'd0) || r !== 3'd0)
      $display("FAIL wcnt_two got=%h/%0d required=%h/0", d, r,
               WC_ON ? 32'd2 : 32'd0);
    else passed++;
  endtask

  task automatic test_strobe();
    logic [2:0] r; logic l; logic [31:0] d;
    do_reset();
    wr(8'h04, 32'h0000_0000, 5'hF, r, l);
    wr(8'h04, 32'hAABB_CCDD, 5'h5, r, l);
    rd(8'h04, d, r, l);
    total++;
    if (d !== 32'h00BB_00DD)
      $display("FAIL strb_5 got=%h required=00bb00dd", d);
    else passed++;
    wr(8'h04, 32'h1122_3344, 5'h10, r, l);
    wr(8'h04, 32'h5566_7788, 5'h0, r, l);
    total++;
    if (r !== 3'd0) $display("FAIL strb_0_resp got=%0d required=0", r);
    else passed++;
    rd(8'h04, d, r, l);
    total++;
    if (d !== 32'h00BB_00DD)
      $display("FAIL strb_none got=%h required=00bb00dd", d);
    else passed++;
    rd(8'h0C, d, r, l);
    total++;
    if (d !== (WC_ON ? 32'd4 : 32'd0))
      $display("FAIL wcnt_strb got=%h required=%h", d,
               WC_ON ? 32'd4 : 32'd0);
    else passed++;
  endtask

  task automatic test_errors();
    logic [2:0] r; logic l; logic [31:0] d;
    wr(8'h08, 32'h1234_5678, 5'hF, r, l);
    total++;
    if (r !== 3'd2) $display("FAIL err_w08 got=%0d required=2", r);
    else passed++;
    wr(8'h02, 32'h1234_5678, 5'hF, r, l);
    total++;
    if (r !== 3'd2) $display("FAIL err_w02 got=%0d required=2", r);
    else passed++;
    wr(8'h10, 32'h1234_5678, 5'hF, r, l);
    total++;
    if (r !== 3'd2) $display("FAIL err_w10 got=%0d required=2", r);
    else passed++;
    rd(8'h00, d, r, l);
    total++;
    if (d !== 32'h0) $display("FAIL err_ctrl got=%h required=0", d);
    else passed++;
    rd(8'h04, d, r, l);
    total++;
    if (d !== 32'h00BB_00DD)
      $display("FAIL err_data got=%h required=00bb00dd", d);
    else passed++;
    rd(8'h0C, d, r, l);
    total++;
    if (d !== (WC_ON ? 32'd4 : 32'd0))
      $display("FAIL err_wcnt got=%h required=%h", d,
               WC_ON ? 32'd4 : 32'd0);
    else passed++;
    rd(8'h14, d, r, l);
    total++;
    if (d !== 32'h0 || r !== 3'd2)
      $display("FAIL err_r14 got=%h/%0d required=0/2", d, r);
    else passed++;
    rd(8'h03, d, r, l);
    total++;
    if (d !== 32'h0 || r !== 3'd2)
      $display("FAIL err_r03 got=%h/%0d required=0/2", d, r);
    else passed++;
  endtask

  task automatic test_w_first();
    logic [2:0] r; logic l; logic [31:0] d;
    @(negedge clk);
    wdata = 32'h0000_1234; wstrb = 5'hF; wvalid = 1; bready = 0;
    @(posedge clk); #1;
    wvalid = 0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({wready, awready} !== 2'b01)
        $display("FAIL wfirst_ready got=%b required=01", {wready, awready});
      else passed++;
    end
    @(negedge clk);
    awaddr = 8'h04; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    total++;
    if (bvalid !== 1'b1) $display("FAIL wfirst_blat got=%b required=1", bvalid);
    else passed++;
    repeat (4) begin
      @(negedge clk);
      total++;
      if ({bvalid, bresp, awready, wready} !== 6'b100000)
        $display("FAIL wfirst_hold got=%b required=100000",
                 {bvalid, bresp, awready, wready});
      else passed++;
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    total++;
    if ({bvalid, awready, wready} !== 3'b011)
      $display("FAIL wfirst_done got=%b required=011",
               {bvalid, awready, wready});
    else passed++;
    rd(8'h04, d, r, l);
    total++;
    if (d !== 32'h0000_1234)
      $display("FAIL wfirst_data got=%h required=00001234", d);
    else passed++;
  endtask

  task automatic test_same_edge();
    logic [2:0] r; logic l; logic [31:0] d;
    wr(8'h00, 32'h0000_0011, 5'hF, r, l);
    @(negedge clk);
    awaddr = 8'h00; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    @(negedge clk);
    wdata = 32'h0000_0022; wstrb = 5'hF; wvalid = 1;
    araddr = 8'h00; arvalid = 1; rready = 1; bready = 1;
    total++;
    if ({wready, arready} !== 2'b11)
      $display("FAIL same_ready got=%b required=11", {wready, arready});
    else passed++;
    @(posedge clk); #1;
    wvalid = 0; arvalid = 0;
    total++;
    if ({rvalid, bvalid} !== 2'b11 || rdata !== 32'h11)
      $display("FAIL same_old got=%b/%h required=11/00000011",
               {rvalid, bvalid}, rdata);
    else passed++;
    @(posedge clk); #1;
    rready = 0; bready = 0;
    rd(8'h00, d, r, l);
    total++;
    if (d !== 32'h22) $display("FAIL same_new got=%h required=00000022", d);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int na, nr;
    na = 0; nr = 0;
    @(negedge clk);
    awaddr = 8'h04; wdata = 32'h7; wstrb = 5'hF;
    awvalid = 1; wvalid = 1; bready = 1;
    araddr = 8'h04; arvalid = 1; rready = 1;
    for (int i = 0; i < 10; i++) begin
      if (awvalid & awready) na++;
      if (arvalid & arready) nr++;
      @(negedge clk);
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    total++;
    if (na !== 5) $display("FAIL b2b_aw got=%0d required=5", na);
    else passed++;
    total++;
    if (nr !== 5) $display("FAIL b2b_ar got=%0d required=5", nr);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [2:0] r; logic l; logic [31:0] d;
    wr(8'h00, 32'h0000_0033, 5'hF, r, l);
    @(negedge clk);
    awaddr = 8'h04; wdata = 32'h44; wstrb = 5'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    total++;
    if (bvalid !== 1'b1) $display("FAIL mid_pending got=%b required=1", bvalid);
    else passed++;
    @(negedge clk);
    aresetn = 0;
    @(posedge clk); #1;
    total++;
    if (bvalid !== 1'b0) $display("FAIL mid_drop got=%b required=0", bvalid);
    else passed++;
    @(negedge clk);
    aresetn = 1;
    @(posedge clk); #1;
    rd(8'h00, d, r, l);
    total++;
    if (d !== 32'h0) $display("FAIL mid_ctrl got=%h required=0", d);
    else passed++;
    rd(8'h04, d, r, l);
    total++;
    if (d !== 32'h0) $display("FAIL mid_data got=%h required=0", d);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sum();
    test_strobe();
    test_errors();
    test_w_first();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

AXI4-Lite responder: a four-word memory-mapped register slave that terminates one master port of the address-decoding bus (`m1_*` or `m2_*`). It accepts single-beat writes and reads, applies byte strobes, and returns OKAY/SLVERR responses. Two words are read/write control/data and two are read-only derived values (sum, write count).

## Interface
- `DATA_WIDTH`, 32, data bus width in bits.
- `ADDR_WIDTH`, 8, byte address width.
- `RESP_WIDTH`, 3, response field width; OKAY = 0, SLVERR = 2.
- `BASE_ADDR`, 0, byte address of word 0; must be 16-byte aligned.

- `s_axi_aclk` in 1: single clock, rising edge.
- `s_axi_aresetn` in 1: synchronous, active-low reset.
- `s_axi_awaddr` in ADDR_WIDTH, `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address channel.
- `s_axi_wdata` in DATA_WIDTH, `s_axi_wstrb` in DATA_WIDTH/8+1, `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data channel; strobe MSB ignored (width matches bus port).
- `s_axi_bresp` out RESP_WIDTH, `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response.
- `s_axi_araddr` in ADDR_WIDTH, `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address.
- `s_axi_rdata` out DATA_WIDTH, `s_axi_rresp` out RESP_WIDTH, `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data.

## Operation
- Register map (offset from BASE_ADDR): 0x0 REG_CTRL RW; 0x4 REG_DATA RW; 0x8 REG_SUM RO = REG_CTRL + REG_DATA mod 2^DATA_WIDTH; 0xC REG_WCNT RO = count of OKAY writes, wraps to 0.
- Decode error (SLVERR, no state change, rdata 0): addr[1:0] != 0, offset >= 0x10, addr < BASE_ADDR, or write to 0x8/0xC.
- Write FSM: W_IDLE -> W_RESP -> W_IDLE.
  - W_IDLE: awready and wready independently high until their channel is captured; AW and W may arrive in either order or the same cycle.
  - Edge on which both are held: strobed bytes written, REG_WCNT incremented if OKAY, bresp set, bvalid = 1, both readies = 0, enter W_RESP.
  - W_RESP: bvalid/bresp held stable until bready; on bvalid&bready, bvalid = 0, readies = 1, W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready = 1; on arvalid, rdata/rresp registered, rvalid = 1, arready = 0.
  - R_DATA: rdata/rresp/rvalid held until rready; then rvalid = 0, arready = 1.
- Read and write FSMs are independent; both may be active at once.

## Timing
- Reset values: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; all registers 0; FSMs in idle. Readies rise on the first edge after reset release.
- Write latency: last of AW/W handshakes in cycle N -> register updated and bvalid = 1 in cycle N+1.
- Read latency: AR handshake in cycle N -> rvalid = 1 with data in cycle N+1.
- Simultaneous write commit and AR handshake on the same edge: read returns the pre-write value.
- Back-to-back: with bready/rready held high, a new transaction is accepted every 2 cycles per channel.
- Reset asserted mid-transaction: pending response dropped, registers cleared, no partial write.
- wstrb = 0 on a valid address: OKAY, no bytes change, REG_WCNT still increments.

## Configuration
- `AXI_REG_SLAVE_WCNT_EN` defined: REG_WCNT implemented as above.
- Not defined: counter logic omitted; reads of 0xC return 0 with OKAY; writes to 0xC remain SLVERR.

## Test plan
- Reset then write 0x0 = 0x0000_0005, strb 0xF; read 0x0 -> 0x0000_0005, OKAY; bvalid one cycle after handshake.
- Write 0x0 = 0xFFFF_FFFF, write 0x4 = 0x0000_0002; read 0x8 -> 0x0000_0001 (wrap); read 0xC -> 2 (with macro) or 0 (without).
- Write 0x4 = 0xAABB_CCDD with strb 0x5 over 0; read 0x4 -> 0x00BB_00DD.
- Write to 0x8, addr 0x2, addr 0x10 -> bresp 2, no register change, REG_WCNT unchanged; read 0x14 -> rresp 2, rdata 0.
- W presented 3 cycles before AW, bready held low 4 cycles -> bvalid stable, awready/wready low until B handshake.
- AR and final W handshake on the same cycle to 0x0 -> read returns old value; reset asserted during W_RESP -> bvalid 0 next cycle, registers 0.
